// File: rtl/zigzag_buf.sv
// Ping-pong 8x8 block buffer: raster-order coefficients in, JPEG zigzag order out.
// Define ZIGZAG_LAST_EN to add the out_last port, which marks zigzag index 63.
module zigzag_buf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
`ifdef ZIGZAG_LAST_EN
    ,
    output logic              out_last
`endif
);

    // Raster position read for zigzag output k
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    logic [DATA_W-1:0] mem_q [128];

    logic              wb_q;
    logic [5:0]        wcnt_q;
    logic [1:0]        full_q;
    logic [1:0]        full_d;

    state_t            state_q;
    logic              rb_q;
    logic [5:0]        rcnt_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              last_q;

    logic              wr_fire;
    logic              wr_done;
    logic              rd_load;
    logic              rd_done;
    logic [6:0]        rd_addr;

    assign in_ready = ~full_q[wb_q];
    assign wr_fire  = in_valid & in_ready;
    assign wr_done  = wr_fire & (wcnt_q == 6'd63);

    // After index 63 is accepted rb already points at the other bank,
    // so full_q[rb_q] decides between a seamless restart and going idle.
    always_comb begin
        rd_load = 1'b0;
        case (state_q)
            S_IDLE:   rd_load = full_q[rb_q];
            S_STREAM: rd_load = out_ready & (~last_q | full_q[rb_q]);
            default:  rd_load = 1'b0;
        endcase
    end

    assign rd_done = rd_load & (rcnt_q == 6'd63);
    assign rd_addr = {rb_q, ZZ[rcnt_q]};

    // Set and clear never hit the same bank: the writer only fills an empty
    // bank and the reader only drains a full one.
    always_comb begin
        full_d = full_q;
        if (wr_done) full_d[wb_q] = 1'b1;
        if (rd_done) full_d[rb_q] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[{wb_q, wcnt_q}] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q   <= 1'b0;
            wcnt_q <= 6'd0;
            full_q <= 2'b00;
        end else begin
            full_q <= full_d;
            if (wr_fire) begin
                wcnt_q <= wcnt_q + 6'd1;
                if (wr_done) wb_q <= ~wb_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rb_q    <= 1'b0;
            rcnt_q  <= 6'd0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rd_load) state_q <= S_STREAM;
                end
                S_STREAM: begin
                    if (out_ready && last_q && !full_q[rb_q]) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            if (rd_load) begin
                data_q  <= mem_q[rd_addr];
                valid_q <= 1'b1;
                last_q  <= (rcnt_q == 6'd63);
                rcnt_q  <= rcnt_q + 6'd1;
                if (rd_done) rb_q <= ~rb_q;
            end
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
`ifdef ZIGZAG_LAST_EN
    assign out_last  = last_q;
`endif

endmodule

// File: tb/tb_zigzag_buf.sv
// Directed bench for zigzag_buf: scoreboard of zigzag-ordered expectations,
// handshake latency, stall stability, back-pressure and mid-block reset.
module tb_zigzag_buf;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
`ifdef ZIGZAG_LAST_EN
    logic       out_last;
`endif

    zigzag_buf #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef ZIGZAG_LAST_EN
        ,
        .out_last  (out_last)
`endif
    );

    always #5 clk = ~clk;

    int zz [64] = '{
        0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    logic [7:0] src_q [$];
    logic [7:0] exp_q [$];
    logic       exp_last_q [$];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   in_acc = 0;
    int   out_cnt = 0;
    int   first_out = -1;
    int   last_out = -1;
    int   rdy_drop = 0;
    bit   ordy = 1'b0;
    bit   ordy_toggle = 1'b0;
    bit   ordy_phase = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_block(input int base, input bit ff0);
        logic [7:0] raster [64];
        for (int r = 0; r < 64; r++) begin
            raster[r] = 8'(base + r);
            if (ff0 && r == 0) raster[r] = 8'hFF;
            src_q.push_back(raster[r]);
        end
        for (int k = 0; k < 64; k++) begin
            exp_q.push_back(raster[zz[k]]);
            exp_last_q.push_back(k == 63);
        end
    endtask

    task automatic step();
        logic       ifire;
        logic       ofire;
        logic       stall;
        logic [7:0] od;
        logic [7:0] e;
        logic       el;
`ifdef ZIGZAG_LAST_EN
        logic       ol;
`endif
        in_valid  = (src_q.size() > 0);
        in_data   = in_valid ? src_q[0] : 8'h00;
        out_ready = ordy_toggle ? ordy_phase : ordy;
        #1;
        ifire = in_valid & in_ready;
        ofire = out_valid & out_ready;
        stall = out_valid & ~out_ready;
        od    = out_data;
`ifdef ZIGZAG_LAST_EN
        ol    = out_last;
`endif
        if (in_valid && !in_ready) rdy_drop++;
        @(posedge clk);
        #1;
        cyc++;
        ordy_phase = ~ordy_phase;
        if (ifire) begin
            void'(src_q.pop_front());
            in_acc++;
        end
        if (ofire) begin
            out_cnt++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            if (exp_q.size() == 0) begin
                chk("extra_output", 32'd1, 32'd0);
            end else begin
                e  = exp_q.pop_front();
                el = exp_last_q.pop_front();
                chk("data", {24'd0, od}, {24'd0, e});
                $display("out #%0d data=%0d", out_cnt, od);
`ifdef ZIGZAG_LAST_EN
                chk("last", {31'd0, ol}, {31'd0, el});
`else
                if (el) $display("end of block at out #%0d", out_cnt);
`endif
            end
        end
        if (stall) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_data", {24'd0, out_data}, {24'd0, od});
`ifdef ZIGZAG_LAST_EN
            chk("hold_last", {31'd0, out_last}, {31'd0, ol});
`endif
        end
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && (exp_q.size() > 0 || src_q.size() > 0); i++) step();
        chk("drain_exp_empty", exp_q.size(), 32'd0);
        chk("drain_src_empty", src_q.size(), 32'd0);
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
`ifdef ZIGZAG_LAST_EN
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // single block, latency of first output
        ordy = 1'b1;
        push_block(0, 1'b0);
        for (int i = 0; i < 200 && src_q.size() > 0; i++) step();
        chk("t1_valid_at_N", {31'd0, out_valid}, 32'd0);
        step();
        chk("t1_valid_at_N1", {31'd0, out_valid}, 32'd1);
        chk("t1_first_data", {24'd0, out_data}, 32'd0);
        drain(200);

        // two blocks back to back, no bubble
        out_cnt = 0; first_out = -1; last_out = -1; rdy_drop = 0;
        push_block(0, 1'b0);
        push_block(100, 1'b0);
        drain(400);
        chk("t2_out_count", out_cnt, 32'd128);
        chk("t2_out_span", last_out - first_out + 1, 32'd128);
        chk("t2_in_ready_drop", rdy_drop, 32'd0);

        // back-pressure with three blocks offered
        ordy = 1'b0; in_acc = 0;
        push_block(0, 1'b0);
        push_block(64, 1'b0);
        push_block(128, 1'b0);
        for (int i = 0; i < 400 && in_acc < 128; i++) step();
        chk("t3_accepted", in_acc, 32'd128);
        chk("t3_in_ready_low", {31'd0, in_ready}, 32'd0);
        repeat (10) step();
        chk("t3_accepted_stall", in_acc, 32'd128);
        chk("t3_out_valid", {31'd0, out_valid}, 32'd1);
        chk("t3_out_data_hold", {24'd0, out_data}, 32'd0);
        ordy = 1'b1;
        drain(600);

        // alternating out_ready, FF at raster 0
        ordy_toggle = 1'b1; ordy_phase = 1'b1; out_cnt = 0;
        push_block(0, 1'b1);
        drain(400);
        chk("t4_out_count", out_cnt, 32'd64);
        ordy_toggle = 1'b0;

        // reset mid-block
        in_acc = 0;
        push_block(0, 1'b0);
        for (int i = 0; i < 100 && in_acc < 30; i++) step();
        in_valid = 1'b0;
        rst = 1'b1;
        #2;
        chk("t5_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_rst_out_data", {24'd0, out_data}, 32'd0);
        chk("t5_rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef ZIGZAG_LAST_EN
        chk("t5_rst_out_last", {31'd0, out_last}, 32'd0);
`endif
        src_q.delete();
        exp_q.delete();
        exp_last_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_cnt = 0;
        push_block(0, 1'b0);
        drain(300);
        chk("t5_out_count", out_cnt, 32'd64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
